// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit,
// each held for BAUD_DIV clock cycles. out[15] flags that a new byte can be loaded.
module uart_tx #(
    parameter int BAUD_DIV = 216
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] in,
    output logic        TX,
    output logic [15:0] out
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] baud_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shreg_r;
    logic [7:0]  shreg_s;
    logic        tx_r;
    logic        tx_s;
    logic        bit_end_s;
    logic        unused_s;

    assign bit_end_s = (baud_r == BAUD_LAST);
    // The upper input byte carries no meaning for this block.
    assign unused_s  = ^in[15:8];
    assign TX        = tx_r;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load) state_s = START;
                else      state_s = IDLE;
            end
            START: begin
                if (bit_end_s) state_s = DATA;
                else           state_s = START;
            end
            DATA: begin
                if (bit_end_s && (bit_idx_r == 3'd7)) state_s = STOP;
                else                                  state_s = DATA;
            end
            STOP: begin
                if (bit_end_s) state_s = IDLE;
                else           state_s = STOP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Shift register next value: capture on accept, shift at each data bit end
    always_comb begin
        shreg_s = shreg_r;
        if ((state_r == IDLE) && load) begin
            shreg_s = in[7:0];
        end else if ((state_r == DATA) && bit_end_s) begin
            shreg_s = {1'b0, shreg_r[7:1]};
        end else begin
            shreg_s = shreg_r;
        end
    end

    // Output decode: ready flag from current state, line level for the next cycle
    always_comb begin
        out  = 16'h0000;
        tx_s = 1'b1;
        if (state_r == IDLE) out = 16'h8000;
        else                 out = 16'h0000;
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = shreg_s[0];
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // Datapath registers: line driver, baud counter, bit index, shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_r      <= 1'b1;
            baud_r    <= 16'd0;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'd0;
        end else begin
            tx_r    <= tx_s;
            shreg_r <= shreg_s;
            if ((state_r == IDLE) || bit_end_s) begin
                baud_r <= 16'd0;
            end else begin
                baud_r <= baud_r + 16'd1;
            end
            if ((state_r == DATA) && bit_end_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end else if (state_r == START) begin
                bit_idx_r <= 3'd0;
            end else begin
                bit_idx_r <= bit_idx_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model compared every cycle,
// plus literal frame captures, back-to-back spacing, mid-frame reset and default-rate timing.
module tb_uart_tx;

    localparam int B = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        load216 = 1'b0;
    logic [15:0] din = 16'h0000;
    logic [15:0] din216 = 16'h0000;
    logic        tx4, tx216;
    logic [15:0] out4, out216;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx #(.BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .load(load), .in(din), .TX(tx4), .out(out4)
    );

    uart_tx dut216 (
        .clk(clk), .reset(reset), .load(load216), .in(din216), .TX(tx216), .out(out216)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame accepted at some edge occupies the next 10*B cycles;
    // cycle p of the frame shows frame bit p/B = {stop, byte, start}.
    int         cyc = 0;
    int         c0 = 0;
    bit         active = 1'b0;
    logic [7:0] mbyte = 8'h00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            active = 1'b0;
        end else begin
            if (load && (!active || (cyc - c0) >= 10 * B)) begin
                active = 1'b1;
                c0     = cyc + 1;
                mbyte  = din[7:0];
            end
            cyc = cyc + 1;
        end
    end

    function automatic bit model_idle();
        return reset || !active || ((cyc - c0) >= 10 * B);
    endfunction

    function automatic logic model_tx();
        int k;
        if (model_idle()) return 1'b1;
        k = (cyc - c0) / B;
        if (k == 0) return 1'b0;
        if (k <= 8) return mbyte[k-1];
        return 1'b1;
    endfunction

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_tx", tx4, model_tx());
            check("model_out", out4, model_idle() ? 32'h8000 : 32'h0000);
        end
    end

    // Sends one byte and captures the mid-bit line level of each of the ten frame bits.
    task automatic send_cap(input logic [15:0] d, input int inject_at,
                            output logic [9:0] cap, output int busy);
        load = 1'b1;
        din  = d;
        @(negedge clk);
        load = 1'b0;
        din  = 16'($urandom);
        busy = 0;
        cap  = 10'h000;
        for (int p = 0; p < 10 * B + 4; p++) begin
            if (out4 == 16'h0000) busy++;
            if ((p % B == 1) && (p / B < 10)) cap[p / B] = tx4;
            if (p == inject_at) begin
                load = 1'b1;
                din  = 16'h0000;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    logic [9:0]  cap;
    int          busy;
    logic [15:0] r;
    int          prev, last, falls, len, runs;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_tx", tx4, 1'b1);
        check("reset_out", out4, 16'h8000);
        reset = 1'b0;
        @(negedge clk);

        send_cap(16'h0055, -1, cap, busy);
        check("frame_55", cap, 10'h2AA);
        check("latency_55", busy, 40);

        send_cap(16'hFFA3, -1, cap, busy);
        check("frame_A3", cap, 10'h346);

        send_cap(16'h00C3, 9, cap, busy);
        check("frame_C3_ignore_load", cap, 10'h386);
        check("latency_C3", busy, 40);

        // Held load: start bits must fall every 10*B+1 cycles.
        load  = 1'b1;
        din   = 16'h00FF;
        prev  = 1;
        last  = -1;
        falls = 0;
        for (int p = 0; p < 140; p++) begin
            @(negedge clk);
            if (prev == 1 && tx4 == 1'b0) begin
                if (last >= 0) check("b2b_period", p - last, 41);
                last = p;
                falls++;
            end
            prev = int'(tx4);
        end
        check("b2b_frames", falls, 4);
        load = 1'b0;
        repeat (45) @(negedge clk);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 9) == 0);
            din  = 16'($urandom);
        end
        load = 1'b0;
        repeat (45) @(negedge clk);

        // Reset in the middle of data bit 3 (chosen to be 0 so the forced high is visible).
        r    = 16'($urandom) & 16'hFFF7;
        load = 1'b1;
        din  = r;
        @(negedge clk);
        load = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_reset_bit3", tx4, 1'b0);
        #7;
        reset = 1'b1;
        #1;
        check("async_reset_tx", tx4, 1'b1);
        check("async_reset_out", out4, 16'h8000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        r = 16'($urandom);
        send_cap(r, -1, cap, busy);
        check("frame_after_reset", cap, {1'b1, r[7:0], 1'b0});
        check("latency_after_reset", busy, 40);

        // Default rate: every bit 216 cycles wide, frame 2160 cycles.
        load216 = 1'b1;
        din216  = 16'hAB55;
        @(negedge clk);
        load216 = 1'b0;
        prev = int'(tx216);
        len  = 1;
        runs = 0;
        busy = (out216 == 16'h0000) ? 1 : 0;
        for (int p = 1; p < 2200; p++) begin
            @(negedge clk);
            if (out216 == 16'h0000) busy++;
            if (int'(tx216) == prev) begin
                len++;
            end else begin
                if (runs < 9) check("bit_width_216", len, 216);
                runs++;
                len  = 1;
                prev = int'(tx216);
            end
        end
        check("transitions_216", runs, 9);
        check("latency_216", busy, 2160);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
